// File: rtl/banked_ram.sv
// -----------------------------------------------------------------------------
// banked_ram
//   Synchronous multi-bank word RAM for the CPU data path.
//
//   The upper BANK_SEL_W address bits pick a bank and the low WIDX_W bits pick
//   a word inside it. Every address bit in between must be zero, otherwise the
//   access is rejected with rsp_err. Each request runs IDLE -> ACCESS -> RESP,
//   so a response appears two cycles after acceptance. A clear sequence walks
//   all word indices and zeroes that word in every bank in parallel.
//
// Ports
//   clk        : clock, all state changes on the rising edge
//   rst_n      : asynchronous active-low reset (array contents are kept)
//   req_valid  : request present
//   req_ready  : request can be accepted this cycle
//   req_rw     : 1 = write, 0 = read
//   req_addr   : word address
//   req_wdata  : write data
//   req_be     : byte enables for writes (ignored on reads)
//   rsp_valid  : response present
//   rsp_ready  : consumer accepts the response
//   rsp_rdata  : read data, 0 for writes and errors
//   rsp_err    : address out of range; the array was not touched
//   clr_start  : pulse that starts zeroing all banks (sampled in IDLE only)
//   clr_busy   : clear sequence in progress
// -----------------------------------------------------------------------------
module banked_ram #(
  parameter int DATA_W         = 32,
  parameter int ADDR_W         = 32,
  parameter int BANK_SEL_W     = 8,
  parameter int NUM_BANKS      = 8,
  parameter int WORDS_PER_BANK = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_rw,
  input  logic [ADDR_W-1:0]     req_addr,
  input  logic [DATA_W-1:0]     req_wdata,
  input  logic [DATA_W/8-1:0]   req_be,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_W-1:0]     rsp_rdata,
  output logic                  rsp_err,
  input  logic                  clr_start,
  output logic                  clr_busy
);

  localparam int WIDX_W = $clog2(WORDS_PER_BANK);
  localparam int BE_W   = DATA_W / 8;

  // Address bits below the bank field.
  localparam logic [ADDR_W-1:0] LOW_MASK  =
    {{BANK_SEL_W{1'b0}}, {(ADDR_W-BANK_SEL_W){1'b1}}};
  localparam logic [ADDR_W-1:0] WORD_MASK = ADDR_W'(WORDS_PER_BANK - 1);
  // Bits between the word index and the bank field; any 1 here is an error.
  localparam logic [ADDR_W-1:0] MID_MASK  = LOW_MASK & ~WORD_MASK;

  // One extra bit so NUM_BANKS == 2**BANK_SEL_W is representable.
  localparam logic [BANK_SEL_W:0] NB_LIM    = (BANK_SEL_W+1)'(NUM_BANKS);
  localparam logic [WIDX_W-1:0]   WORD_LAST = WIDX_W'(WORDS_PER_BANK - 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_RESP   = 2'd2,
    S_CLEAR  = 2'd3
  } state_t;

  // Control state
  state_t              state_q, state_d;
  logic [WIDX_W-1:0]   cnt_q, cnt_d;
  logic [DATA_W-1:0]   rsp_rdata_q, rsp_rdata_d;
  logic                rsp_err_q, rsp_err_d;

  // Captured request (data path, not reset)
  logic                rw_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [DATA_W-1:0]   wdata_q;
  logic [BE_W-1:0]     be_q;

  // Decode of the captured address
  logic [BANK_SEL_W-1:0] bank_sel;
  logic [WIDX_W-1:0]     word_sel;
  logic                  addr_err;

  // Array strobes
  logic                acc_we;
  logic                clr_we;
  logic [DATA_W-1:0]   bank_rd [NUM_BANKS];
  logic [DATA_W-1:0]   rd_word;

  logic                accept;

  // clr_start takes priority over a same-cycle request, so it also masks ready.
  assign req_ready = (state_q == S_IDLE) && !clr_start;
  assign accept    = req_valid && req_ready;
  assign rsp_valid = (state_q == S_RESP);
  assign clr_busy  = (state_q == S_CLEAR);
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;

  assign bank_sel = addr_q[ADDR_W-1 -: BANK_SEL_W];
  assign word_sel = addr_q[WIDX_W-1:0];
  assign addr_err = ({1'b0, bank_sel} >= NB_LIM) || ((addr_q & MID_MASK) != '0);

  // ---------------------------------------------------------------------------
  // Request capture: IDLE -> ACCESS boundary
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (accept) begin
      rw_q    <= req_rw;
      addr_q  <= req_addr;
      wdata_q <= req_wdata;
      be_q    <= req_be;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state and response logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;
    acc_we      = 1'b0;
    clr_we      = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (clr_start) begin
          state_d = S_CLEAR;
        end else if (req_valid) begin
          state_d = S_ACCESS;
        end
      end

      S_ACCESS: begin
        state_d = S_RESP;
        if (addr_err) begin
          rsp_rdata_d = '0;
          rsp_err_d   = 1'b1;
        end else if (rw_q) begin
          acc_we      = 1'b1;
          rsp_rdata_d = '0;
          rsp_err_d   = 1'b0;
        end else begin
          rsp_rdata_d = rd_word;
          rsp_err_d   = 1'b0;
        end
      end

      S_RESP: begin
        if (rsp_ready) begin
          state_d     = S_IDLE;
          rsp_rdata_d = '0;
          rsp_err_d   = 1'b0;
        end
      end

      S_CLEAR: begin
        clr_we = 1'b1;
        if (cnt_q == WORD_LAST) begin
          cnt_d   = '0;
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q + WIDX_W'(1);
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Control registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Bank storage: cleared in parallel, written only when its index matches
  // ---------------------------------------------------------------------------
  for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
    logic [DATA_W-1:0] mem_q [WORDS_PER_BANK];
    logic              hit;

    assign hit        = (bank_sel == BANK_SEL_W'(b));
    assign bank_rd[b] = mem_q[word_sel];

    always_ff @(posedge clk) begin
      if (clr_we) begin
        mem_q[cnt_q] <= '0;
      end else if (acc_we && hit) begin
        for (int i = 0; i < BE_W; i++) begin
          if (be_q[i]) begin
            mem_q[word_sel][i*8 +: 8] <= wdata_q[i*8 +: 8];
          end
        end
      end
    end
  end

  // Read mux over the bank outputs; only consulted when addr_err is low.
  always_comb begin
    rd_word = '0;
    for (int b = 0; b < NUM_BANKS; b++) begin
      if (bank_sel == BANK_SEL_W'(b)) begin
        rd_word = bank_rd[b];
      end
    end
  end

endmodule

// File: tb/tb_banked_ram.sv
module tb_banked_ram;

  logic        clk;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic        req_rw;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [3:0]  req_be;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        clr_start;
  logic        clr_busy;

  int checks   = 0;
  int failures = 0;

  banked_ram #(
    .DATA_W(32), .ADDR_W(32), .BANK_SEL_W(8), .NUM_BANKS(8), .WORDS_PER_BANK(32)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_rw(req_rw),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .rsp_err(rsp_err), .clr_start(clr_start), .clr_busy(clr_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic        rw;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
    logic [31:0] exp_rdata;
    logic        exp_err;
  } vec_t;

  vec_t vecs[18];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%08h required=0x%08h", name, act, exp);
    end
  endtask

  // One complete transaction with rsp_ready held high.
  task automatic do_access(input string tag, input logic rw, input logic [31:0] addr,
                           input logic [31:0] wdata, input logic [3:0] be,
                           input logic [31:0] exp_rdata, input logic exp_err);
    @(negedge clk);
    rsp_ready = 1'b1;
    req_valid = 1'b1;
    req_rw    = rw;
    req_addr  = addr;
    req_wdata = wdata;
    req_be    = be;
    #1;
    chk({tag, "_ready"}, req_ready, 1);
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    req_addr  = 32'hFFFF_FFFF;
    chk({tag, "_t1_valid"}, rsp_valid, 0);
    chk({tag, "_t1_ready"}, req_ready, 0);
    @(negedge clk);
    chk({tag, "_t2_valid"}, rsp_valid, 1);
    chk({tag, "_rdata"}, rsp_rdata, exp_rdata);
    chk({tag, "_err"}, rsp_err, exp_err);
    @(negedge clk);
    chk({tag, "_done_valid"}, rsp_valid, 0);
    chk({tag, "_done_err"}, rsp_err, 0);
    chk({tag, "_done_ready"}, req_ready, 1);
  endtask

  initial begin
    int busy;
    logic [7:0] bb;
    logic [4:0] ww;

    vecs[0]  = '{1'b1, 32'h0000_0005, 32'hDEAD_BEEF, 4'hF, 32'h0,         1'b0};
    vecs[1]  = '{1'b0, 32'h0000_0005, 32'h0,         4'hF, 32'hDEAD_BEEF, 1'b0};
    vecs[2]  = '{1'b1, 32'h0100_0003, 32'h1111_1111, 4'hF, 32'h0,         1'b0};
    vecs[3]  = '{1'b1, 32'h0700_0003, 32'h2222_2222, 4'hF, 32'h0,         1'b0};
    vecs[4]  = '{1'b0, 32'h0100_0003, 32'h0,         4'h0, 32'h1111_1111, 1'b0};
    vecs[5]  = '{1'b0, 32'h0700_0003, 32'h0,         4'h0, 32'h2222_2222, 1'b0};
    vecs[6]  = '{1'b1, 32'h0000_0005, 32'h0000_00AA, 4'h1, 32'h0,         1'b0};
    vecs[7]  = '{1'b0, 32'h0000_0005, 32'h0,         4'h0, 32'hDEAD_BEAA, 1'b0};
    vecs[8]  = '{1'b0, 32'h0800_0000, 32'h0,         4'h0, 32'h0,         1'b1};
    vecs[9]  = '{1'b0, 32'h0000_0020, 32'h0,         4'h0, 32'h0,         1'b1};
    vecs[10] = '{1'b0, 32'h0000_0005, 32'h0,         4'h0, 32'hDEAD_BEAA, 1'b0};
    vecs[11] = '{1'b1, 32'h0000_0025, 32'hFFFF_FFFF, 4'hF, 32'h0,         1'b1};
    vecs[12] = '{1'b1, 32'h0000_0005, 32'h1234_5678, 4'h6, 32'h0,         1'b0};
    vecs[13] = '{1'b0, 32'h0000_0005, 32'h0,         4'h0, 32'hDE34_56AA, 1'b0};
    vecs[14] = '{1'b0, 32'hFF00_0005, 32'h0,         4'h0, 32'h0,         1'b1};
    vecs[15] = '{1'b1, 32'h0700_001F, 32'h3333_3333, 4'hF, 32'h0,         1'b0};
    vecs[16] = '{1'b0, 32'h0700_001F, 32'h0,         4'h0, 32'h3333_3333, 1'b0};
    vecs[17] = '{1'b0, 32'h0001_0000, 32'h0,         4'h0, 32'h0,         1'b1};

    rst_n     = 1'b0;
    req_valid = 1'b0;
    req_rw    = 1'b0;
    req_addr  = '0;
    req_wdata = '0;
    req_be    = '0;
    rsp_ready = 1'b1;
    clr_start = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_req_ready", req_ready, 1);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rsp_rdata", rsp_rdata, 0);
    chk("rst_rsp_err", rsp_err, 0);
    chk("rst_clr_busy", clr_busy, 0);

    for (int i = 0; i < 18; i++) begin
      do_access($sformatf("v%0d", i), vecs[i].rw, vecs[i].addr, vecs[i].wdata,
                vecs[i].be, vecs[i].exp_rdata, vecs[i].exp_err);
    end

    // Backpressure on a read, with a clr_start pulse in RESP that must be dropped.
    @(negedge clk);
    rsp_ready = 1'b0;
    req_valid = 1'b1;
    req_rw    = 1'b0;
    req_addr  = 32'h0100_0003;
    #1 chk("bp_ready", req_ready, 1);
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    chk("bp_t1_valid", rsp_valid, 0);
    @(negedge clk);
    chk("bp_t2_valid", rsp_valid, 1);
    chk("bp_t2_rdata", rsp_rdata, 32'h1111_1111);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk($sformatf("bp_hold%0d_valid", k), rsp_valid, 1);
      chk($sformatf("bp_hold%0d_rdata", k), rsp_rdata, 32'h1111_1111);
      chk($sformatf("bp_hold%0d_ready", k), req_ready, 0);
      clr_start = (k == 1);
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    chk("bp_rel_valid", rsp_valid, 0);
    chk("bp_rel_ready", req_ready, 1);
    chk("bp_rel_busy", clr_busy, 0);
    @(negedge clk);
    chk("bp_after_valid", rsp_valid, 0);
    chk("bp_after_busy", clr_busy, 0);

    // Clear wins over a same-cycle request; a second pulse mid-clear is ignored.
    @(negedge clk);
    clr_start = 1'b1;
    req_valid = 1'b1;
    req_rw    = 1'b1;
    req_addr  = 32'h0000_0007;
    req_wdata = 32'h5555_5555;
    req_be    = 4'hF;
    #1 chk("clr_req_ready", req_ready, 0);
    @(posedge clk);
    @(negedge clk);
    clr_start = 1'b0;
    req_valid = 1'b0;
    busy = 0;
    for (int c = 0; c < 100; c++) begin
      if (!clr_busy) break;
      busy++;
      if (rsp_valid !== 1'b0) chk("clr_no_rsp", rsp_valid, 0);
      clr_start = (busy == 10);
      @(negedge clk);
    end
    clr_start = 1'b0;
    chk("clr_cycles", busy, 32);
    #1 chk("clr_end_ready", req_ready, 1);
    chk("clr_end_valid", rsp_valid, 0);

    for (int b = 0; b < 8; b++) begin
      for (int w = 0; w < 32; w++) begin
        bb = 8'(b);
        ww = 5'(w);
        do_access($sformatf("sweep_b%0d_w%0d", b, w), 1'b0, {bb, 19'd0, ww},
                  32'h0, 4'h0, 32'h0, 1'b0);
      end
    end

    // Reset while a read response is pending: response is dropped.
    do_access("pre_w", 1'b1, 32'h0000_0005, 32'hA5A5_A5A5, 4'hF, 32'h0, 1'b0);
    @(negedge clk);
    rsp_ready = 1'b0;
    req_valid = 1'b1;
    req_rw    = 1'b0;
    req_addr  = 32'h0000_0005;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    chk("rr_valid", rsp_valid, 1);
    chk("rr_rdata", rsp_rdata, 32'hA5A5_A5A5);
    rst_n = 1'b0;
    #1;
    chk("rr_rst_valid", rsp_valid, 0);
    chk("rr_rst_rdata", rsp_rdata, 0);
    chk("rr_rst_ready", req_ready, 1);
    @(negedge clk);
    rst_n     = 1'b1;
    rsp_ready = 1'b1;
    @(negedge clk);
    chk("rr_post_valid", rsp_valid, 0);

    // Reset during clear: aborts, leaving the upper words untouched.
    do_access("pre_w2", 1'b1, 32'h0200_001F, 32'hCAFE_F00D, 4'hF, 32'h0, 1'b0);
    @(negedge clk);
    clr_start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    clr_start = 1'b0;
    repeat (4) @(negedge clk);
    chk("rc_busy", clr_busy, 1);
    chk("rc_ready", req_ready, 0);
    rst_n = 1'b0;
    #1;
    chk("rc_rst_busy", clr_busy, 0);
    chk("rc_rst_ready", req_ready, 1);
    chk("rc_rst_valid", rsp_valid, 0);
    chk("rc_rst_err", rsp_err, 0);
    chk("rc_rst_rdata", rsp_rdata, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rc_post_busy", clr_busy, 0);
    do_access("rc_keep", 1'b0, 32'h0200_001F, 32'h0, 4'h0, 32'hCAFE_F00D, 1'b0);
    do_access("rc_zero", 1'b0, 32'h0200_0000, 32'h0, 4'h0, 32'h0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/banked_ram.md
Name: banked_ram

Overview:
- Synchronous, parametrised multi-bank word RAM for the CPU data path.
- Successor to the combinational chip-select RAM.
- Upper address bits select a bank and low bits select a word. Accesses use a valid/ready request and response handshake.
- Adds byte-enable writes, out-of-range error responses and a hardware clear sequence that zeroes every bank.

Parameters:
- DATA_W, 32, word width in bits; must be a multiple of 8.
- ADDR_W, 32, request address width.
- BANK_SEL_W, 8, number of address MSBs forming the bank index: address[ADDR_W-1 -: BANK_SEL_W].
- NUM_BANKS, 8, number of banks instantiated; must be 1..2^BANK_SEL_W.
- WORDS_PER_BANK, 32, words per bank; must be a power of two. WIDX_W = clog2(WORDS_PER_BANK).

Ports:
- clk  in  1  single clock, all state on rising edge
- rst_n  in  1  asynchronous active-low reset
- req_valid  in  1  request present
- req_ready  out  1  block can accept a request this cycle
- req_rw  in  1  1=write, 0=read
- req_addr  in  ADDR_W  word address
- req_wdata  in  DATA_W  write data
- req_be  in  DATA_W/8  byte enables for writes; ignored on reads
- rsp_valid  out  1  response present
- rsp_ready  in  1  consumer accepts response
- rsp_rdata  out  DATA_W  read data; 0 for writes and errors
- rsp_err  out  1  address out of range; no array effect
- clr_start  in  1  pulse: begin zeroing all banks
- clr_busy  out  1  clear sequence in progress

Behaviour:
- Reset (async assert, sync release): FSM=IDLE; req_ready=1, rsp_valid=0, rsp_rdata=0, rsp_err=0, clr_busy=0, clear counter=0.
  - Array contents are not reset.
  - Reset mid-access or mid-clear aborts it. No response is issued, and partially cleared memory stays partial.
- Decode:
  - bank = addr[ADDR_W-1 -: BANK_SEL_W]; word = addr[WIDX_W-1:0].
  - Out of range if bank >= NUM_BANKS, or if any bit addr[ADDR_W-BANK_SEL_W-1:WIDX_W] is nonzero.
- FSM states IDLE, ACCESS, RESP, CLEAR.
- IDLE:
  - req_ready=1.
  - clr_start has priority over req_valid in the same cycle: go to CLEAR and do not accept the request, because req_ready is 0 that cycle.
  - Otherwise, on req_valid&&req_ready, register rw/addr/wdata/be and go to ACCESS.
- ACCESS (one cycle), req_ready=0:
  - Only the decoded bank is touched.
  - Write: update the bytes with be[i]=1; other bytes are unchanged.
  - Read: capture the word into rsp_rdata.
  - Error: no array access; rsp_rdata=0, rsp_err=1.
  - Go to RESP.
- RESP:
  - rsp_valid=1; hold rsp_rdata/rsp_err stable until rsp_ready.
  - On rsp_valid&&rsp_ready, go to IDLE and clear rsp_valid/rsp_err.
- Latency: a request accepted in cycle T gets rsp_valid in cycle T+2. Max throughput is one access per 3 cycles when rsp_ready=1.
- Read-after-write to the same address returns the new data. Writes always produce a response with rsp_rdata=0.
- CLEAR:
  - clr_busy=1, req_ready=0.
  - Each cycle, write 0 to word[cnt] of all banks in parallel and increment cnt.
  - After cnt=WORDS_PER_BANK-1, reset cnt to 0 and go to IDLE. Clear takes exactly WORDS_PER_BANK cycles.
  - clr_start is ignored outside IDLE, including while in CLEAR.
- clr_start in RESP is ignored; it is not queued.
- Request inputs are don't-care while req_ready=0.

Test Plan:
- Reset then write 0xDEADBEEF to 0x0000_0005 (be=4'hF), then read 0x0000_0005 -> write rsp at T+2 err=0; read rsp_rdata=0xDEADBEEF at T+2.
- Bank isolation: write 0x11111111 to 0x0100_0003 and 0x22222222 to 0x0700_0003 -> reads return each value independently.
- Byte enable: word=0xDEADBEEF, write 0x000000AA be=4'b0001 -> read 0xDEADBEAA.
- Errors: read 0x0800_0000 and read 0x0000_0020 -> rsp_err=1, rsp_rdata=0; a following read of 0x0000_0005 is unchanged.
- Backpressure: hold rsp_ready=0 for 5 cycles during a read -> rsp_valid and rsp_rdata stay stable, req_ready=0; release -> exactly one response consumed, IDLE the next cycle.
- Clear: fill several words, pulse clr_start together with req_valid -> clr_busy high for exactly 32 cycles, request not accepted; afterwards every bank/word reads 0. Assert rst_n low mid-clear -> outputs return to reset values immediately.
